// File: rtl/run_length_detector.sv
// Mealy run-length detector: flags runs of equal samples on a at two thresholds and reports run end/length.
// Define RLD_MAXRUN_EN to build the longest-run tracker; otherwise max_run is tied to 0.
module run_length_detector #(
    parameter int CNT_W    = 4,
    parameter int THRESH_X = 2,
    parameter int THRESH_Y = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             a,
    output logic             x,
    output logic             y,
    output logic             run_end,
    output logic [CNT_W-1:0] run_len,
    output logic             run_val,
    output logic [CNT_W-1:0] max_run
);

    localparam int RMAX = (1 << CNT_W) - 1;
    localparam logic [CNT_W-1:0] RMAX_V = CNT_W'(RMAX);
    localparam logic [CNT_W-1:0] TX     = CNT_W'(THRESH_X);
    localparam logic [CNT_W-1:0] TY     = CNT_W'(THRESH_Y);

    // Out-of-range thresholds would silently truncate into the counter width.
    if (THRESH_X < 1 || THRESH_X > RMAX || THRESH_Y < THRESH_X || THRESH_Y > RMAX) begin : g_bad_params
        $fatal(1, "run_length_detector: illegal THRESH_X/THRESH_Y for CNT_W");
    end

    logic             has_prev;
    logic             match;
    logic             accept;
    logic [CNT_W-1:0] len_eff;

    // len_eff is the length the run would have including this sample; it saturates at RMAX.
    always_comb begin
        match   = has_prev & (a == run_val);
        accept  = en & ~clr;
        len_eff = CNT_W'(1);
        if (match) begin
            if (run_len == RMAX_V) begin
                len_eff = run_len;
            end else begin
                len_eff = run_len + CNT_W'(1);
            end
        end
        x       = accept & (len_eff >= TX);
        y       = accept & (len_eff >= TY);
        run_end = accept & has_prev & ~match;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            has_prev <= 1'b0;
            run_val  <= 1'b0;
            run_len  <= '0;
        end else if (clr) begin
            has_prev <= 1'b0;
            run_val  <= 1'b0;
            run_len  <= '0;
        end else if (en) begin
            has_prev <= 1'b1;
            run_val  <= a;
            run_len  <= len_eff;
        end
    end

`ifdef RLD_MAXRUN_EN
    // len_eff never exceeds RMAX, so the maximum saturates with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            max_run <= '0;
        end else if (clr) begin
            max_run <= '0;
        end else if (en && (len_eff > max_run)) begin
            max_run <= len_eff;
        end
    end
`else
    assign max_run = '0;
`endif

endmodule

// File: tb/tb_run_length_detector.sv
// Directed self-checking bench for run_length_detector: default, CNT_W=3 saturation and THRESH_X=1/THRESH_Y=4 instances.
module tb_run_length_detector;

    logic clk;
    logic reset;
    logic en [3];
    logic clr [3];
    logic a [3];
    logic x [3];
    logic y [3];
    logic run_end [3];
    logic run_val [3];
    logic [3:0] len0, len2, mr0, mr2;
    logic [2:0] len1, mr1;

    int checkCount = 0;
    int passCount  = 0;

    run_length_detector u_dut (
        .clk(clk), .reset(reset), .clr(clr[0]), .en(en[0]), .a(a[0]),
        .x(x[0]), .y(y[0]), .run_end(run_end[0]), .run_len(len0),
        .run_val(run_val[0]), .max_run(mr0)
    );

    run_length_detector #(.CNT_W(3)) u_sat (
        .clk(clk), .reset(reset), .clr(clr[1]), .en(en[1]), .a(a[1]),
        .x(x[1]), .y(y[1]), .run_end(run_end[1]), .run_len(len1),
        .run_val(run_val[1]), .max_run(mr1)
    );

    run_length_detector #(.THRESH_X(1), .THRESH_Y(4)) u_thr (
        .clk(clk), .reset(reset), .clr(clr[2]), .en(en[2]), .a(a[2]),
        .x(x[2]), .y(y[2]), .run_end(run_end[2]), .run_len(len2),
        .run_val(run_val[2]), .max_run(mr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checkCount++;
        if (obs === expv) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, expv, $time);
        end
    endtask

    // Drive one instance's inputs after the falling edge, leaving time before Mealy sampling.
    task automatic applyStimulus(input int idx, input logic e, input logic c, input logic d);
        @(negedge clk);
        en[idx]  = e;
        clr[idx] = c;
        a[idx]   = d;
        #1;
    endtask

    task automatic nextEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] seqA, expX, expY, expE;
        logic [4:0] gateEn, gateX, gateY;
        int gateLen [5];
        int expMax;

        for (int i = 0; i < 3; i++) begin
            en[i] = 1'b0; clr[i] = 1'b0; a[i] = 1'b0;
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_run_len", 32'(len0), 0);
        checkOutput("reset_run_val", 32'(run_val[0]), 0);
        checkOutput("reset_max_run", 32'(mr0), 0);
        @(negedge clk);
        reset = 1'b0;

        // Basic pattern; vectors listed oldest sample at bit 6.
        seqA = 7'b0001110;
        expX = 7'b0110110;
        expY = 7'b0010010;
        expE = 7'b0001001;
        for (int i = 6; i >= 0; i--) begin
            applyStimulus(0, 1'b1, 1'b0, seqA[i]);
            checkOutput($sformatf("basic_x[%0d]", 6 - i), 32'(x[0]), 32'(expX[i]));
            checkOutput($sformatf("basic_y[%0d]", 6 - i), 32'(y[0]), 32'(expY[i]));
            checkOutput($sformatf("basic_end[%0d]", 6 - i), 32'(run_end[0]), 32'(expE[i]));
            if (i == 3) checkOutput("basic_end_len", 32'(len0), 3);
            nextEdge();
        end
        checkOutput("basic_run_len", 32'(len0), 1);
        checkOutput("basic_run_val", 32'(run_val[0]), 0);

        // Extend the zero run to 2, then clear together with en.
        applyStimulus(0, 1'b1, 1'b0, 1'b0);
        nextEdge();
        checkOutput("preclr_len", 32'(len0), 2);
        applyStimulus(0, 1'b1, 1'b1, 1'b0);
        checkOutput("clr_x", 32'(x[0]), 0);
        checkOutput("clr_y", 32'(y[0]), 0);
        checkOutput("clr_end", 32'(run_end[0]), 0);
        nextEdge();
        checkOutput("clr_len", 32'(len0), 0);

        // Gated enable with a held high.
        gateEn = 5'b10101;
        gateX  = 5'b00101;
        gateY  = 5'b00001;
        gateLen = '{1, 1, 2, 2, 3};
        for (int i = 4; i >= 0; i--) begin
            applyStimulus(0, gateEn[i], 1'b0, 1'b1);
            checkOutput($sformatf("gate_x[%0d]", 4 - i), 32'(x[0]), 32'(gateX[i]));
            checkOutput($sformatf("gate_y[%0d]", 4 - i), 32'(y[0]), 32'(gateY[i]));
            nextEdge();
            checkOutput($sformatf("gate_len[%0d]", 4 - i), 32'(len0), 32'(gateLen[4 - i]));
        end

        // Longest-run tracking from a cleared state.
        applyStimulus(0, 1'b0, 1'b1, 1'b0);
        nextEdge();
        checkOutput("mr_after_clr", 32'(mr0), 0);
        seqA = 7'b1111001;
        for (int i = 6; i >= 0; i--) begin
            applyStimulus(0, 1'b1, 1'b0, seqA[i]);
            nextEdge();
        end
`ifdef RLD_MAXRUN_EN
        expMax = 4;
`else
        expMax = 0;
`endif
        checkOutput("max_run", 32'(mr0), 32'(expMax));
        checkOutput("mr_run_val", 32'(run_val[0]), 1);

        // Asynchronous reset between edges.
        applyStimulus(0, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput("async_len", 32'(len0), 0);
        checkOutput("async_val", 32'(run_val[0]), 0);
        checkOutput("async_max", 32'(mr0), 0);
        #1;
        reset = 1'b0;
        applyStimulus(0, 1'b1, 1'b0, 1'b1);
        checkOutput("post_reset_x", 32'(x[0]), 0);
        checkOutput("post_reset_end", 32'(run_end[0]), 0);
        nextEdge();
        checkOutput("post_reset_len", 32'(len0), 1);
        applyStimulus(0, 1'b0, 1'b0, 1'b1);

        // Saturation with a 3-bit counter.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1, 1'b1, 1'b0, 1'b1);
            checkOutput($sformatf("sat_x[%0d]", i), 32'(x[1]), (i >= 1) ? 1 : 0);
            checkOutput($sformatf("sat_y[%0d]", i), 32'(y[1]), (i >= 2) ? 1 : 0);
            checkOutput($sformatf("sat_end[%0d]", i), 32'(run_end[1]), 0);
            nextEdge();
            checkOutput($sformatf("sat_len[%0d]", i), 32'(len1), (i + 1 > 7) ? 7 : i + 1);
        end
        applyStimulus(1, 1'b1, 1'b0, 1'b0);
        checkOutput("sat_break_end", 32'(run_end[1]), 1);
        checkOutput("sat_break_len", 32'(len1), 7);
        checkOutput("sat_break_x", 32'(x[1]), 0);
        nextEdge();
        checkOutput("sat_new_len", 32'(len1), 1);
        applyStimulus(1, 1'b0, 1'b0, 1'b0);

        // Custom thresholds with alternating input.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(2, 1'b1, 1'b0, 1'(i % 2));
            checkOutput($sformatf("thr_x[%0d]", i), 32'(x[2]), 1);
            checkOutput($sformatf("thr_y[%0d]", i), 32'(y[2]), 0);
            checkOutput($sformatf("thr_end[%0d]", i), 32'(run_end[2]), (i > 0) ? 1 : 0);
            nextEdge();
            checkOutput($sformatf("thr_len[%0d]", i), 32'(len2), 1);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
